// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter_if
//  Description : Bundle of writeback-source handshakes, issue/decode
//                scoreboard signals and register-file write-port outputs
//                used by rf_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Single-cycle ALU writeback source
    logic                 alu_valid;
    logic                 alu_ready;
    logic [AW-1:0]        alu_rd;
    logic [XLEN-1:0]      alu_wd;

    // Long-latency (load/MUL) writeback source
    logic                 mem_valid;
    logic                 mem_ready;
    logic [AW-1:0]        mem_rd;
    logic [XLEN-1:0]      mem_wd;

    // Long-latency issue and decode-stage hazard query
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 hazard;

    // Register file write port and scoreboard view
    logic                 rf_we;
    logic [AW-1:0]        rf_a3;
    logic [XLEN-1:0]      rf_wd;
    logic [(2**AW)-1:0]   busy;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        output mem_valid, mem_rd, mem_wd,
        output iss_valid, iss_rd, rs1, rs2,
        input  alu_ready, mem_ready, hazard,
        input  rf_we, rf_a3, rf_wd, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        input  mem_valid, mem_rd, mem_wd,
        input  iss_valid, iss_rd, rs1, rs2,
        output alu_ready, mem_ready, hazard,
        output rf_we, rf_a3, rf_wd, busy
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Shares the register file's single write port between the
//                ALU and long-latency writeback paths, keeps a busy bit per
//                register for outstanding long-latency results and flags
//                read-after-write hazards to decode.
//                Optional macro RF_WB_RR_ARB_EN: round-robin arbitration on
//                contention (default: fixed priority, mem over alu).
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int NREG = 2**AW;

    logic              mem_grant;
    logic              alu_grant;
    logic              xfer;
    logic [AW-1:0]     sel_rd;
    logic [XLEN-1:0]   sel_wd;

    logic              rf_we_q;
    logic [AW-1:0]     rf_a3_q;
    logic [XLEN-1:0]   rf_wd_q;

    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic              hz_rs1;
    logic              hz_rs2;

`ifdef RF_WB_RR_ARB_EN
    // Set when mem should win the next contended cycle; flips after each one
    logic              prefer_mem_q;

    // Grant: lone requester wins, contention resolved by the RR preference
    always_comb begin
        mem_grant = 1'b0;
        alu_grant = 1'b0;
        if (rst_n) begin
            if (bus.mem_valid && bus.alu_valid) begin
                mem_grant = prefer_mem_q;
                alu_grant = !prefer_mem_q;
            end else begin
                mem_grant = bus.mem_valid;
                alu_grant = bus.alu_valid;
            end
        end
    end

    // RR pointer advances only on contended cycles so the loser goes next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_mem_q <= 1'b1;
        end else if (bus.mem_valid && bus.alu_valid) begin
            prefer_mem_q <= !prefer_mem_q;
        end
    end
`else
    // Grant: fixed priority, the long-latency path always beats the ALU
    always_comb begin
        mem_grant = rst_n && bus.mem_valid;
        alu_grant = rst_n && bus.alu_valid && !bus.mem_valid;
    end
`endif

    assign bus.mem_ready = mem_grant;
    assign bus.alu_ready = alu_grant;

    // Mux the granted source onto the write-port input
    always_comb begin
        xfer   = mem_grant || alu_grant;
        sel_rd = bus.alu_rd;
        sel_wd = bus.alu_wd;
        if (mem_grant) begin
            sel_rd = bus.mem_rd;
            sel_wd = bus.mem_wd;
        end
    end

    // Registered write port; x0 writes take the slot but never assert we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_a3_q <= '0;
            rf_wd_q <= '0;
        end else if (xfer) begin
            rf_we_q <= (sel_rd != '0);
            rf_a3_q <= sel_rd;
            rf_wd_q <= sel_wd;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    // Scoreboard next state: mem writeback clears, issue sets, set wins
    always_comb begin
        busy_d = busy_q;
        if (mem_grant) begin
            busy_d[bus.mem_rd] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard: source outstanding, or about to be written by the output stage
    always_comb begin
        hz_rs1 = (bus.rs1 != '0) &&
                 (busy_q[bus.rs1] || (rf_we_q && (rf_a3_q == bus.rs1)));
        hz_rs2 = (bus.rs2 != '0) &&
                 (busy_q[bus.rs2] || (rf_we_q && (rf_a3_q == bus.rs2)));
    end

    assign bus.hazard = rst_n && (hz_rs1 || hz_rs2);
    assign bus.rf_we  = rf_we_q;
    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_wd  = rf_wd_q;
    assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter: directed scenarios
//                followed by random traffic, with a behavioural model of the
//                write port and scoreboard feeding an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        ar;
        logic        mr;
        logic        hz;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] busy;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: set of outstanding registers plus last write-port value
    bit          mb [32];
    bit          m_we;
    int          m_a3;
    logic [31:0] m_wd;
    bit          last_win_mem;   // winner of the most recent contended cycle

    // Previous-cycle stimulus, used to honour the hold-while-stalled rule
    bit          p_av, p_mv, p_ga, p_gm;
    int          p_ard, p_mrd;
    logic [31:0] p_awd, p_mwd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 1'b0;
        m_we         = 1'b0;
        m_a3         = 0;
        m_wd         = '0;
        last_win_mem = 1'b0;   // so that mem takes the first contention
    endtask

    function automatic bit reg_hazard(input int r);
        if (r == 0) return 1'b0;
        return mb[r] || (m_we && (m_a3 == r));
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mb[i];
        return v;
    endfunction

    function automatic int rnd_reg();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 7));
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, advance model
    task automatic do_cycle(input bit av, input int ard, input logic [31:0] awd,
                            input bit mv, input int mrd, input logic [31:0] mwd,
                            input bit iv, input int ird, input int r1, input int r2);
        bit   gm, ga;
        exp_t e;
        bus.alu_valid = av;  bus.alu_rd = 5'(ard); bus.alu_wd = awd;
        bus.mem_valid = mv;  bus.mem_rd = 5'(mrd); bus.mem_wd = mwd;
        bus.iss_valid = iv;  bus.iss_rd = 5'(ird);
        bus.rs1 = 5'(r1);    bus.rs2 = 5'(r2);
`ifdef RF_WB_RR_ARB_EN
        if (av && mv) begin
            gm = !last_win_mem;
            ga = last_win_mem;
        end else begin
            gm = mv;
            ga = av;
        end
`else
        gm = mv;
        ga = av && !mv;
`endif
        e.ar   = ga;
        e.mr   = gm;
        e.hz   = reg_hazard(r1) || reg_hazard(r2);
        e.we   = m_we;
        e.a3   = 5'(m_a3);
        e.wd   = m_wd;
        e.busy = busy_vec();
        e.cyc  = cyc;
        expq.push_back(e);
        p_av = av; p_ard = ard; p_awd = awd; p_ga = ga;
        p_mv = mv; p_mrd = mrd; p_mwd = mwd; p_gm = gm;
        @(posedge clk);
        #1;
        if (gm) begin
            m_we = (mrd != 0); m_a3 = mrd; m_wd = mwd;
        end else if (ga) begin
            m_we = (ard != 0); m_a3 = ard; m_wd = awd;
        end else begin
            m_we = 1'b0;
        end
        if (gm) mb[mrd] = 1'b0;
        if (iv && ird != 0) mb[ird] = 1'b1;
        if (av && mv) last_win_mem = gm;
        cyc++;
    endtask

    task automatic idle(input int r1, input int r2);
        do_cycle(0, 0, '0, 0, 0, '0, 0, 0, r1, r2);
    endtask

    // Monitor: compare every queued expectation mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("alu_ready", 32'(bus.alu_ready), 32'(e.ar));
                check("mem_ready", 32'(bus.mem_ready), 32'(e.mr));
                check("hazard",    32'(bus.hazard),    32'(e.hz));
                check("rf_we",     32'(bus.rf_we),     32'(e.we));
                check("rf_a3",     32'(bus.rf_a3),     32'(e.a3));
                check("rf_wd",     bus.rf_wd,          e.wd);
                check("busy",      bus.busy,           e.busy);
            end
        end
    end

    // Stimulus
    initial begin
        bit          av, mv, iv;
        int          ard, mrd, ird;
        logic [31:0] awd, mwd;

        rst_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = '0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_wd = '0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        bus.rs1 = 5'd3; bus.rs2 = 5'd5;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset alu_ready", 32'(bus.alu_ready), 32'd0);
        check("reset mem_ready", 32'(bus.mem_ready), 32'd0);
        check("reset hazard",    32'(bus.hazard),    32'd0);
        check("reset rf_we",     32'(bus.rf_we),     32'd0);
        check("reset rf_a3",     32'(bus.rf_a3),     32'd0);
        check("reset rf_wd",     bus.rf_wd,          32'd0);
        check("reset busy",      bus.busy,           32'd0);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.iss_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write and its one-cycle rf_we pulse
        do_cycle(1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // Both sources contending for three cycles
        for (int i = 0; i < 3; i++)
            do_cycle(1, 3, 32'hA000_0000 + i, 1, 4, 32'hB000_0000 + i, 0, 0, 0, 0);
        idle(0, 0);

        // Issue to x7, hazard, then writeback and hazard drop timing
        do_cycle(0, 0, '0, 0, 0, '0, 1, 7, 0, 0);
        idle(7, 0);
        do_cycle(0, 0, '0, 1, 7, 32'h0000_0777, 0, 0, 7, 0);
        idle(7, 0);
        idle(0, 7);

        // Same-edge issue and writeback of x9: bit stays set
        do_cycle(0, 0, '0, 0, 0, '0, 1, 9, 0, 0);
        do_cycle(0, 0, '0, 1, 9, 32'h0000_0999, 1, 9, 0, 9);
        idle(9, 0);
        do_cycle(0, 0, '0, 1, 9, 32'h0000_9999, 0, 0, 0, 9);
        idle(0, 0);

        // ALU write to x0 consumes the slot without a write
        do_cycle(1, 0, 32'h1234_5678, 0, 0, '0, 0, 0, 0, 0);
        idle(0, 0);

        // Every register outstanding; x0 sources still never stall
        for (int r = 1; r < 32; r++)
            do_cycle(0, 0, '0, 0, 0, '0, 1, r, 0, 0);
        idle(0, 0);
        idle(31, 1);
        for (int r = 1; r < 32; r++)
            do_cycle(0, 0, '0, 1, r, 32'(r), 0, 0, 0, 0);
        idle(0, 0);

        // Mid-cycle asynchronous reset with x12 outstanding and mem pending
        do_cycle(0, 0, '0, 0, 0, '0, 1, 12, 0, 0);
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd12; bus.mem_wd = 32'hCAFE_0012;
        bus.rs1 = 5'd12; bus.rs2 = 5'd0;
        #1;
        check("pre-reset busy",      bus.busy,           32'h0000_1000);
        check("pre-reset mem_ready", 32'(bus.mem_ready), 32'd1);
        check("pre-reset hazard",    32'(bus.hazard),    32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset busy",      bus.busy,           32'd0);
        check("async reset rf_we",     32'(bus.rf_we),     32'd0);
        check("async reset mem_ready", 32'(bus.mem_ready), 32'd0);
        check("async reset hazard",    32'(bus.hazard),    32'd0);
        @(posedge clk);
        #1;
        check("held reset rf_we", 32'(bus.rf_we), 32'd0);
        check("held reset busy",  bus.busy,       32'd0);
        bus.mem_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(0, 0, '0, 1, 12, 32'hCAFE_0012, 0, 0, 12, 0);
        idle(12, 0);
        idle(12, 0);

        // Random traffic honouring the hold-while-stalled rule
        for (int n = 0; n < 3000; n++) begin
            if (p_av && !p_ga) begin
                av = 1'b1; ard = p_ard; awd = p_awd;
            end else begin
                av = ($urandom_range(0, 99) < 55); ard = rnd_reg(); awd = $urandom;
            end
            if (p_mv && !p_gm) begin
                mv = 1'b1; mrd = p_mrd; mwd = p_mwd;
            end else begin
                mv = ($urandom_range(0, 99) < 45); mrd = rnd_reg(); mwd = $urandom;
            end
            iv  = ($urandom_range(0, 99) < 30);
            ird = rnd_reg();
            do_cycle(av, ard, awd, mv, mrd, mwd, iv, ird, rnd_reg(), rnd_reg());
        end
        idle(0, 0);
        @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
